// File: rtl/rgbw_fade_ramp.sv
// RGBW fade ramp: moves four registered PWM duties toward latched targets
// in bounded steps, one step every (divider+1) clocks while any channel differs.
module rgbw_fade_ramp #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       tgt0,
  input  logic [7:0]       tgt1,
  input  logic [7:0]       tgt2,
  input  logic [7:0]       tgt3,
  input  logic             load,
  input  logic [DIV_W-1:0] step_div,
  input  logic [7:0]       step_size,
  output logic [7:0]       duty0,
  output logic [7:0]       duty1,
  output logic [7:0]       duty2,
  output logic [7:0]       duty3,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NCH = 4;
  localparam int unsigned DW  = 8;

  logic [DW-1:0]    duty_q  [NCH];
  logic [DW-1:0]    tgt_q   [NCH];
  logic [DW-1:0]    tgt_in  [NCH];
  logic [DW-1:0]    stepped [NCH];
  logic [DW-1:0]    gap;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] presc_q;
  logic [DW-1:0]    step_q;
  logic             fin_q;
  logic             moving;
  logic             step_evt;
  logic             reach_all;
  logic             load_eq;

  assign tgt_in[0] = tgt0;
  assign tgt_in[1] = tgt1;
  assign tgt_in[2] = tgt2;
  assign tgt_in[3] = tgt3;

  assign duty0 = duty_q[0];
  assign duty1 = duty_q[1];
  assign duty2 = duty_q[2];
  assign duty3 = duty_q[3];

  // Next duty per channel if a step fires now; the step is clipped to the remaining gap.
  always_comb begin
    moving    = 1'b0;
    reach_all = 1'b1;
    load_eq   = 1'b1;
    gap       = '0;
    for (int i = 0; i < NCH; i++) begin
      stepped[i] = duty_q[i];
      gap        = '0;
      if (duty_q[i] != tgt_q[i]) moving = 1'b1;
      if (tgt_in[i] != duty_q[i]) load_eq = 1'b0;
      if (tgt_q[i] > duty_q[i]) begin
        gap        = tgt_q[i] - duty_q[i];
        stepped[i] = duty_q[i] + ((step_q < gap) ? step_q : gap);
      end else if (tgt_q[i] < duty_q[i]) begin
        gap        = duty_q[i] - tgt_q[i];
        stepped[i] = duty_q[i] - ((step_q < gap) ? step_q : gap);
      end
      if (stepped[i] != tgt_q[i]) reach_all = 1'b0;
    end
    step_evt = moving && (presc_q == div_q);
  end

  // fin_q marks the edge a fade completed (or an already-satisfied load); done follows one clock later.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        duty_q[i] <= '0;
        tgt_q[i]  <= '0;
      end
      div_q   <= '0;
      step_q  <= DW'(1);
      presc_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      done  <= fin_q;
      fin_q <= 1'b0;
      if (load) begin
        for (int i = 0; i < NCH; i++) tgt_q[i] <= tgt_in[i];
        div_q   <= step_div;
        step_q  <= (step_size == '0) ? DW'(1) : step_size;
        presc_q <= '0;
        fin_q   <= load_eq;
      end else if (moving) begin
        if (step_evt) begin
          for (int i = 0; i < NCH; i++) duty_q[i] <= stepped[i];
          presc_q <= '0;
          fin_q   <= reach_all;
          busy    <= ~reach_all;
        end else begin
          presc_q <= presc_q + DIV_W'(1);
          busy    <= 1'b1;
        end
      end else begin
        presc_q <= '0;
        busy    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rgbw_fade_ramp.sv
// Bench for rgbw_fade_ramp: constant vector table, directed corner sequences,
// then random traffic checked every cycle against an arithmetic reference model.
module tb_rgbw_fade_ramp;

  localparam int unsigned DIV_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       tgt0, tgt1, tgt2, tgt3;
  logic             load;
  logic [DIV_W-1:0] step_div;
  logic [7:0]       step_size;
  logic [7:0]       duty0, duty1, duty2, duty3;
  logic             busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  rgbw_fade_ramp #(.DIV_W(DIV_W)) dut (
    .clk(clk), .reset(reset),
    .tgt0(tgt0), .tgt1(tgt1), .tgt2(tgt2), .tgt3(tgt3),
    .load(load), .step_div(step_div), .step_size(step_size),
    .duty0(duty0), .duty1(duty1), .duty2(duty2), .duty3(duty3),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        ld;
    logic [31:0] tgt;
    logic [15:0] div;
    logic [7:0]  size;
    logic [31:0] duty;
    logic        bsy;
    logic        dn;
  } vec_t;

  vec_t tbl[$];

  // Reference model state
  int m_duty[4];
  int m_tgt[4];
  int m_div, m_step, m_since;
  bit m_busy, m_done, m_fin;

  function automatic void add(bit r, bit l, logic [31:0] t, logic [15:0] d, logic [7:0] s,
                              logic [31:0] du, bit b, bit dn);
    vec_t v;
    v.rst = r; v.ld = l; v.tgt = t; v.div = d; v.size = s;
    v.duty = du; v.bsy = b; v.dn = dn;
    tbl.push_back(v);
  endfunction

  function automatic logic [33:0] dut_out();
    return {duty0, duty1, duty2, duty3, busy, done};
  endfunction

  function automatic logic [33:0] model_out();
    return {8'(m_duty[0]), 8'(m_duty[1]), 8'(m_duty[2]), 8'(m_duty[3]), m_busy, m_done};
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic bit any_diff();
    bit r = 1'b0;
    for (int i = 0; i < 4; i++) if (m_duty[i] != m_tgt[i]) r = 1'b1;
    return r;
  endfunction

  // Model: a step fires on the (div+1)-th active edge after a load or the previous step.
  function automatic void model_edge(bit r, bit l, logic [31:0] t, int d, int s);
    int nt[4];
    bit eq;
    nt[0] = int'(t[31:24]); nt[1] = int'(t[23:16]); nt[2] = int'(t[15:8]); nt[3] = int'(t[7:0]);
    if (r) begin
      for (int i = 0; i < 4; i++) begin m_duty[i] = 0; m_tgt[i] = 0; end
      m_div = 0; m_step = 1; m_since = 0;
      m_busy = 0; m_done = 0; m_fin = 0;
      return;
    end
    m_done = m_fin;
    m_fin  = 0;
    if (l) begin
      eq = 1'b1;
      for (int i = 0; i < 4; i++) begin
        m_tgt[i] = nt[i];
        if (nt[i] != m_duty[i]) eq = 1'b0;
      end
      m_div   = d;
      m_step  = (s == 0) ? 1 : s;
      m_since = 0;
      m_fin   = eq;
    end else begin
      if (any_diff()) begin
        m_since++;
        if (m_since == m_div + 1) begin
          m_since = 0;
          for (int i = 0; i < 4; i++) begin
            int df = m_tgt[i] - m_duty[i];
            if (df > 0) m_duty[i] += imin(m_step, df);
            else if (df < 0) m_duty[i] -= imin(m_step, -df);
          end
          if (!any_diff()) m_fin = 1;
        end
      end else begin
        m_since = 0;
      end
      m_busy = any_diff();
    end
  endfunction

  task automatic chk(string nm, logic [33:0] act, logic [33:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // One clock: drive at negedge, advance model at posedge, compare 1 time unit later.
  task automatic tick(bit r, bit l, logic [31:0] t, logic [15:0] d, logic [7:0] s);
    @(negedge clk);
    reset = r; load = l;
    tgt0 = t[31:24]; tgt1 = t[23:16]; tgt2 = t[15:8]; tgt3 = t[7:0];
    step_div = d; step_size = s;
    @(posedge clk);
    model_edge(r, l, t, int'(d), int'(s));
    #1;
    chk("model", dut_out(), model_out());
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 32'h5A5A5A5A, 16'd7, 8'd9);
  endtask

  task automatic chk8(string nm, logic [7:0] act, logic [7:0] exp);
    chk(nm, 34'(act), 34'(exp));
  endtask

  initial begin
    reset = 1'b1; load = 1'b0;
    tgt0 = '0; tgt1 = '0; tgt2 = '0; tgt3 = '0;
    step_div = '0; step_size = '0;
    model_edge(1'b1, 1'b0, 32'h0, 0, 0);

    // Reset, then idle with load-only inputs wiggling
    add(1, 0, 32'h0, 16'd0, 8'd0, 32'h0, 0, 0);
    add(1, 0, 32'h0, 16'd0, 8'd0, 32'h0, 0, 0);
    for (int i = 0; i < 10; i++) add(0, 0, 32'hAA55AA55, 16'd3, 8'd7, 32'h0, 0, 0);
    // Basic ramp: tgt0=10, div 3, step 4
    add(0, 1, 32'h0A000000, 16'd3, 8'd4, 32'h0, 0, 0);
    for (int e = 1; e <= 14; e++) begin
      logic [7:0] dv;
      dv = (e >= 12) ? 8'd10 : (e >= 8) ? 8'd8 : (e >= 4) ? 8'd4 : 8'd0;
      add(0, 0, 32'h0, 16'd0, 8'd0, {dv, 24'h0}, (e <= 11), (e == 13));
    end
    // Reach {200,0,50,255} instantly
    add(0, 1, 32'hC80032FF, 16'd0, 8'd255, 32'h0A000000, 0, 0);
    add(0, 0, 32'h0, 16'd0, 8'd0, 32'hC80032FF, 0, 0);
    add(0, 0, 32'h0, 16'd0, 8'd0, 32'hC80032FF, 0, 1);
    // Mixed directions, clamped, instant mode
    add(0, 1, 32'h00FF32FF, 16'd0, 8'd255, 32'hC80032FF, 0, 0);
    add(0, 0, 32'h0, 16'd0, 8'd0, 32'h00FF32FF, 0, 0);
    add(0, 0, 32'h0, 16'd0, 8'd0, 32'h00FF32FF, 0, 1);
    add(0, 0, 32'h0, 16'd0, 8'd0, 32'h00FF32FF, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].rst, tbl[i].ld, tbl[i].tgt, tbl[i].div, tbl[i].size);
      chk($sformatf("table[%0d]", i), dut_out(), {tbl[i].duty, tbl[i].bsy, tbl[i].dn});
    end

    // Retarget mid-fade: ch1 0->100 by 10, reload to 20 at duty1=40
    tick(1'b1, 1'b0, 32'h0, 16'd0, 8'd0);
    tick(1'b0, 1'b1, 32'h00640000, 16'd0, 8'd10);
    idle(4);
    chk8("retarget_pre", duty1, 8'd40);
    tick(1'b0, 1'b1, 32'h00140000, 16'd0, 8'd10);
    chk8("retarget_load", duty1, 8'd40);
    begin
      int pulses = 0;
      tick(1'b0, 1'b0, 32'h0, 16'd0, 8'd0);
      chk8("retarget_30", duty1, 8'd30);
      pulses += int'(done);
      tick(1'b0, 1'b0, 32'h0, 16'd0, 8'd0);
      chk8("retarget_20", duty1, 8'd20);
      pulses += int'(done);
      for (int i = 0; i < 4; i++) begin
        tick(1'b0, 1'b0, 32'h0, 16'd0, 8'd0);
        pulses += int'(done);
      end
      chk("retarget_done_count", 34'(pulses), 34'd1);
    end

    // Load collides with a step event
    tick(1'b1, 1'b0, 32'h0, 16'd0, 8'd0);
    tick(1'b0, 1'b1, 32'hC8000000, 16'd2, 8'd1);
    idle(3);
    chk8("coll_first", duty0, 8'd1);
    idle(2);
    tick(1'b0, 1'b1, 32'hC8000000, 16'd2, 8'd1);
    chk8("coll_nostep", duty0, 8'd1);
    idle(2);
    chk8("coll_wait", duty0, 8'd1);
    idle(1);
    chk8("coll_next", duty0, 8'd2);

    // step_size 0 behaves as 1
    tick(1'b1, 1'b0, 32'h0, 16'd0, 8'd0);
    tick(1'b0, 1'b1, 32'h00000300, 16'd0, 8'd0);
    for (int e = 1; e <= 3; e++) begin
      idle(1);
      chk8($sformatf("size0_step%0d", e), duty2, 8'(e));
    end
    idle(1);
    chk("size0_done", 34'(done), 34'd1);

    // Load of targets equal to current duties
    tick(1'b0, 1'b1, 32'h00000300, 16'd5, 8'd3);
    chk("eq_load_busy", 34'({busy, done}), 34'd0);
    idle(1);
    chk("eq_load_done", 34'({busy, done}), 34'b01);
    idle(1);
    chk("eq_load_after", 34'({busy, done}), 34'd0);

    // Reset mid-ramp
    tick(1'b0, 1'b1, 32'h000000FA, 16'd0, 8'd5);
    idle(5);
    tick(1'b1, 1'b0, 32'h0, 16'd0, 8'd0);
    chk("reset_mid", dut_out(), 34'd0);
    begin
      int pulses = 0;
      for (int i = 0; i < 5; i++) begin
        idle(1);
        pulses += int'(done);
      end
      chk("reset_no_done", 34'(pulses), 34'd0);
    end

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      bit r, l;
      logic [31:0] t;
      logic [15:0] d;
      logic [7:0]  s;
      r = ($urandom_range(0, 299) == 0);
      l = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 3))
          0: t[k*8 +: 8] = 8'h00;
          1: t[k*8 +: 8] = 8'hFF;
          default: t[k*8 +: 8] = 8'($urandom);
        endcase
      end
      d = 16'($urandom_range(0, 4));
      case ($urandom_range(0, 3))
        0: s = 8'd0;
        1: s = 8'd255;
        default: s = 8'($urandom_range(1, 40));
      endcase
      tick(r, l, t, d, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rgbw_fade_ramp.md
Name: rgbw_fade_ramp

Overview:
- Upstream feeder for the 4-channel PWM generator: drives its four 8-bit duty inputs.
- Accepts a target RGBW colour and ramps each registered duty output toward its target in fixed steps at a programmable rate, giving smooth fades.
- The PWM generator buffers duties at its own period boundary, so this block has no PWM-period alignment requirement.

Parameters:
- DIV_W, 16, width of the step-interval divider (clocks between steps).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous reset, active-high.
- tgt0..tgt3  input  8 each  target duty for channels 0..3 (R,G,B,W), sampled on load.
- load  input  1  one-cycle strobe: latch tgt0..3, step_div, step_size.
- step_div  input  DIV_W  clocks per step minus 1 (0 = step every clock).
- step_size  input  8  duty increment per step (0 treated as 1).
- duty0..duty3  output  8 each  registered current duty, to the PWM generator.
- busy  output  1  high while any duty differs from its latched target.
- done  output  1  one-cycle pulse when all channels reach target.

Behaviour:
- One clock domain, single clock clk. Reset is synchronous, active-high, and has priority over all other activity.
- Reset values:
  - duty0..3 = 0
  - latched targets = 0
  - divider reg = 0
  - step reg = 1
  - prescaler = 0
  - busy = 0
  - done = 0
- Load (load=1 at edge E):
  - Latch tgt0..3 into target regs.
  - Latch step_div, and step_size (0 mapped to 1).
  - Clear prescaler to 0.
  - Duties are unchanged at E.
  - step_div and step_size are ignored outside load.
- Prescaler, each edge while busy and not loading:
  - If prescaler == divider reg: step event; prescaler <= 0.
  - Else prescaler <= prescaler + 1.
  - First step occurs divider+1 edges after the load edge.
  - Prescaler holds at 0 while not busy.
- Step event, per channel independently:
  - diff = target - duty, 9-bit signed.
  - If diff > 0: duty += min(step, diff).
  - If diff < 0: duty -= min(step, -diff).
  - If diff = 0: hold.
  - No overshoot, no wrap: 8-bit duty never passes its target or 0/255.
- Load and a step event at the same edge: load wins; no step that edge.
- busy: registered; equals (duty != target) for any channel, evaluated on the post-edge values. It rises at the edge after a load with any difference.
- done:
  - Pulses high for exactly one cycle at the edge after busy goes 1->0 due to a step.
  - A load whose targets all equal the current duties also yields one done pulse at the edge after the load edge; busy stays 0 in that case.
- Retargeting mid-fade: a new load while busy takes the latched targets immediately. The fade continues from the current duties, and the prescaler restarts at 0.
- Reset mid-fade: all duties return to 0 at that edge. No done pulse.
- Latency: tgt-to-duty change is divider+1 clocks after the load edge; the full ramp takes ceil(max|diff|/step) steps.

Test Plan:
- Reset then idle: assert reset 2 cycles -> duty0..3=0, busy=0, done=0; hold 10 cycles with no load -> no change.
- Basic ramp up: load tgt0=10, others 0, step_div=3, step_size=4 -> duty0 goes 4,8,10 at edges +4, +8, +12 after load; busy=1 from edge +1 through +11; done pulse at edge +13; other channels stay 0.
- Mixed directions, instant mode: from duties {200,0,50,255}, load tgt={0,255,50,255}, step_size=255, step_div=0 -> all channels reach target at edge +1 (no wrap, clamped); done pulse at edge +2.
- Retarget mid-fade: ramp ch1 0->100 with step 10, div 0; at duty1=40 load tgt1=20 -> duty1 goes 30,20; prescaler restarts; done pulses once only, after duty1=20.
- Load collides with step: load asserted on the same edge the prescaler hits divider -> no step that edge; next step occurs divider+1 edges later.
- Edge cases:
  - step_size=0 is treated as 1: 0->3 takes 3 steps.
  - Load of targets equal to current duties -> busy stays 0, one done pulse.
  - Reset asserted mid-ramp -> duties 0 at that edge, no done.
